// File: rtl/r_empty_ctrl_pkg.sv
// Shared pointer helpers for the dual-clock FIFO read and write controllers:
// pointer width, depth sanity check and gray<->binary conversion.
package r_empty_ctrl_pkg;

  // Converters work on a wide word. Callers zero-extend and slice back to the
  // pointer width, so one pair of functions serves any ADDRESS_SIZE.
  localparam int GRAY_W = 32;
  typedef logic [GRAY_W-1:0] gray_word_t;

  function automatic int ptr_width(input int address_size);
    return address_size + 1;
  endfunction

  function automatic bit depth_ok(input int address_size, input int memory_depth);
    return memory_depth == (1 << address_size);
  endfunction

  function automatic gray_word_t bin_to_gray(input gray_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic gray_word_t gray_to_bin(input gray_word_t gray);
    gray_word_t bin;
    bin[GRAY_W-1] = gray[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage : r_empty_ctrl_pkg

// File: rtl/r_empty_ctrl_if.sv
// Read-side FIFO control bus: consumer request, write-domain gray pointer in,
// read pointer, RAM address and status flags out.
interface r_empty_ctrl_if
  import r_empty_ctrl_pkg::*;
#(
  parameter int ADDRESS_SIZE = 4
);

  localparam int PTR_W = ptr_width(ADDRESS_SIZE);

  logic                    r_en;
  logic [PTR_W-1:0]        w_ptr;
  logic [PTR_W-1:0]        r_ptr;
  logic [ADDRESS_SIZE-1:0] r_addr;
  logic                    r_empty;
  logic                    r_almost_empty;
  logic [PTR_W-1:0]        r_level;
  logic                    r_underflow;

  // Consumer / write-domain side
  modport master (
    output r_en,
    output w_ptr,
    input  r_ptr,
    input  r_addr,
    input  r_empty,
    input  r_almost_empty,
    input  r_level,
    input  r_underflow
  );

  // Read controller side
  modport slave (
    input  r_en,
    input  w_ptr,
    output r_ptr,
    output r_addr,
    output r_empty,
    output r_almost_empty,
    output r_level,
    output r_underflow
  );

endinterface : r_empty_ctrl_if

// File: rtl/r_ptr_sync.sv
// Multi-flop synchronizer that brings the gray write pointer into the read
// clock domain. Only gray-coded values may be passed through it.
module r_ptr_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("r_ptr_sync: STAGES must be at least 2");
  end

  logic [WIDTH-1:0] r_chain [STAGES];

  // NOTE: the chain is a handful of flops, not a RAM, so every stage is reset;
  // non-blocking updates let each stage sample its neighbour's old value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_chain[i] <= '0;
      end
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule : r_ptr_sync

// File: rtl/r_empty_ctrl.sv
// Read-domain controller of the dual-clock FIFO: read pointer, RAM address,
// synchronised write pointer and registered empty / level / underflow flags.
module r_empty_ctrl
  import r_empty_ctrl_pkg::*;
#(
  parameter int ADDRESS_SIZE = 4,
  parameter int MEMORY_DEPTH = 16,
  parameter int AE_THRESH    = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic          r_clk,
  input  logic          r_rst,
  r_empty_ctrl_if.slave bus
);

  localparam int PTR_W = ptr_width(ADDRESS_SIZE);

  if (!depth_ok(ADDRESS_SIZE, MEMORY_DEPTH)) begin : g_bad_depth
    $error("r_empty_ctrl: MEMORY_DEPTH must equal 2**ADDRESS_SIZE");
  end

  logic [PTR_W-1:0] r_bin;
  logic [PTR_W-1:0] r_gptr;
  logic [PTR_W-1:0] r_level;
  logic             r_empty;
  logic             r_almost_empty;
  logic             r_underflow;

  logic [PTR_W-1:0] w_rq_wptr;
  logic [PTR_W-1:0] w_rq_wbin;
  logic [PTR_W-1:0] w_bnext;
  logic [PTR_W-1:0] w_gnext;
  logic [PTR_W-1:0] w_level_next;
  logic             w_rd_ok;

  r_ptr_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .i_clk (r_clk),
    .i_rst (r_rst),
    .i_d   (bus.w_ptr),
    .o_q   (w_rq_wptr)
  );

  // Reads are gated by the registered flag, so a write pointer that is still
  // in the synchronizer can never enable a read of an unwritten word.
  assign w_rd_ok      = bus.r_en & ~r_empty;
  assign w_bnext      = r_bin + PTR_W'(w_rd_ok);
  assign w_gnext      = PTR_W'(bin_to_gray(GRAY_W'(w_bnext)));
  assign w_rq_wbin    = PTR_W'(gray_to_bin(GRAY_W'(w_rq_wptr)));
  assign w_level_next = w_rq_wbin - w_bnext;

  // Flags look at the post-read pointer, so empty rises on the very edge that
  // consumes the last word.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_bin          <= '0;
      r_gptr         <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_level        <= '0;
      r_underflow    <= 1'b0;
    end else begin
      r_bin          <= w_bnext;
      r_gptr         <= w_gnext;
      r_empty        <= (w_gnext == w_rq_wptr);
      r_almost_empty <= (w_level_next <= PTR_W'(AE_THRESH));
      r_level        <= w_level_next;
      r_underflow    <= r_underflow | (bus.r_en & r_empty);
    end
  end

  assign bus.r_ptr          = r_gptr;
  assign bus.r_addr         = r_bin[ADDRESS_SIZE-1:0];
  assign bus.r_empty        = r_empty;
  assign bus.r_almost_empty = r_almost_empty;
  assign bus.r_level        = r_level;
  assign bus.r_underflow    = r_underflow;

endmodule : r_empty_ctrl
